// File: rtl/accel_frame_packer.sv
// accel_frame_packer: steps the accelerometer axis select X/Y/Z, captures
// one 16-bit sample per axis after a dwell, then streams the three samples
// as a byte frame (A5, SEQ, XL, XH, YL, YH, ZL, ZH[, CHK]) over valid/ready.
// Optional feature macro: FRAME_CHECKSUM_EN appends an XOR checksum byte.
module accel_frame_packer #(
    parameter int DWELL_CYCLES = 4096,
    parameter int DWELL_W      = 13
) (
    input  logic       iSPI_CLK,
    input  logic       iRST,
    input  logic [7:0] iDATA_L,
    input  logic [7:0] iDATA_H,
    output logic [1:0] oDIMENSION,
    output logic [7:0] oTX_DATA,
    output logic       oTX_VALID,
    input  logic       iTX_READY,
    output logic [7:0] oSEQ
);

    typedef enum logic {
        ST_DWELL = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

`ifdef FRAME_CHECKSUM_EN
    localparam logic [3:0] LAST = 4'd8;
`else
    localparam logic [3:0] LAST = 4'd7;
`endif

    localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL_CYCLES - 1);

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         dim_q, dim_d;
    logic [3:0]         idx_q, idx_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic [7:0]         seq_q, seq_d;
    logic [15:0]        smp_x_q, smp_x_d;
    logic [15:0]        smp_y_q, smp_y_d;
    logic [15:0]        smp_z_q, smp_z_d;

    logic [3:0]         idx_nxt;
    logic [7:0]         nxt_byte;
    logic               xfer;

    assign idx_nxt = idx_q + 4'd1;
    assign xfer    = valid_q & iTX_READY;

    // Byte that follows the one currently presented, from frozen samples.
    always_comb begin
        nxt_byte = 8'h00;
        case (idx_nxt)
            4'd1:    nxt_byte = seq_q;
            4'd2:    nxt_byte = smp_x_q[7:0];
            4'd3:    nxt_byte = smp_x_q[15:8];
            4'd4:    nxt_byte = smp_y_q[7:0];
            4'd5:    nxt_byte = smp_y_q[15:8];
            4'd6:    nxt_byte = smp_z_q[7:0];
            4'd7:    nxt_byte = smp_z_q[15:8];
`ifdef FRAME_CHECKSUM_EN
            4'd8:    nxt_byte = seq_q
                              ^ smp_x_q[7:0] ^ smp_x_q[15:8]
                              ^ smp_y_q[7:0] ^ smp_y_q[15:8]
                              ^ smp_z_q[7:0] ^ smp_z_q[15:8];
`endif
            default: nxt_byte = 8'h00;
        endcase
    end

    // Next-state logic for dwell/capture sequencing and frame emission.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dim_d   = dim_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        seq_d   = seq_q;
        smp_x_d = smp_x_q;
        smp_y_d = smp_y_q;
        smp_z_d = smp_z_q;
        case (state_q)
            ST_DWELL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    case (dim_q)
                        2'd0:    smp_x_d = {iDATA_H, iDATA_L};
                        2'd1:    smp_y_d = {iDATA_H, iDATA_L};
                        default: smp_z_d = {iDATA_H, iDATA_L};
                    endcase
                    if (dim_q != 2'd2) begin
                        dim_d = dim_q + 2'd1;
                    end else begin
                        state_d = ST_SEND;
                        valid_d = 1'b1;
                        data_d  = 8'hA5;
                        idx_d   = 4'd0;
                    end
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (idx_q == LAST) begin
                        valid_d = 1'b0;
                        seq_d   = seq_q + 8'd1;
                        dim_d   = 2'd0;
                        cnt_d   = '0;
                        state_d = ST_DWELL;
                    end else begin
                        idx_d  = idx_nxt;
                        data_d = nxt_byte;
                    end
                end
            end
            default: state_d = ST_DWELL;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge iSPI_CLK) begin
        if (iRST) begin
            state_q <= ST_DWELL;
            cnt_q   <= '0;
            dim_q   <= 2'd0;
            idx_q   <= 4'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            seq_q   <= 8'h00;
            smp_x_q <= 16'h0000;
            smp_y_q <= 16'h0000;
            smp_z_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dim_q   <= dim_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            seq_q   <= seq_d;
            smp_x_q <= smp_x_d;
            smp_y_q <= smp_y_d;
            smp_z_q <= smp_z_d;
        end
    end

    assign oDIMENSION = dim_q;
    assign oTX_DATA   = data_q;
    assign oTX_VALID  = valid_q;
    assign oSEQ       = seq_q;

endmodule

// File: tb/tb_accel_frame_packer.sv
// Bench for accel_frame_packer: directed frames plus randomized samples
// and backpressure checked against a frame-level reference model.
module tb_accel_frame_packer;

    localparam int D = 4;

`ifdef FRAME_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dl, dh;
    logic [1:0] dim;
    logic [7:0] txd;
    logic       txv;
    logic       txr;
    logic [7:0] seq;

    logic [15:0] axis_val [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        dl = 8'h00;
        dh = 8'h00;
        if (dim < 2'd3) begin
            dl = axis_val[dim][7:0];
            dh = axis_val[dim][15:8];
        end
    end

    accel_frame_packer #(.DWELL_CYCLES(D), .DWELL_W(13)) dut (
        .iSPI_CLK   (clk),
        .iRST       (rst),
        .iDATA_L    (dl),
        .iDATA_H    (dh),
        .oDIMENSION (dim),
        .oTX_DATA   (txd),
        .oTX_VALID  (txv),
        .iTX_READY  (txr),
        .oSEQ       (seq)
    );

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {7'd0, txv}, 8'h00);
        check({tag, "_dim"}, {6'd0, dim}, 8'h00);
        check({tag, "_seq"}, seq, 8'h00);
        check({tag, "_data"}, txd, 8'h00);
    endtask

    // mode: 0 ready high, 1 random ready, 2 stall 5 cycles at idx 3,
    //       3 change X during send, 4 reset at idx 4
    task automatic run_frame(input logic [7:0] sq, input int mode);
        logic [15:0] cap [3];
        logic [7:0]  exp_b [$];
        logic [7:0]  chk;
        int          i;
        int          cyc;
        int          stall;
        for (int k = 0; k < 3 * D; k++) begin
            txr = 1'($urandom);
            check("dwell_valid", {7'd0, txv}, 8'h00);
            check("dwell_dim", {6'd0, dim}, 8'(k / D));
            if (k % D == D - 1) cap[k / D] = axis_val[k / D];
            @(posedge clk);
            @(negedge clk);
        end
        exp_b = {8'hA5, sq,
                 cap[0][7:0], cap[0][15:8],
                 cap[1][7:0], cap[1][15:8],
                 cap[2][7:0], cap[2][15:8]};
        chk = 8'h00;
        for (int j = 1; j < 8; j++) chk ^= exp_b[j];
        if (NB == 9) exp_b.push_back(chk);
        if (mode == 3) axis_val[0] = 16'($urandom);
        i = 0;
        cyc = 0;
        stall = 0;
        while (i < NB) begin
            if (mode == 4 && i == 4) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                check_reset_outputs("midrst");
                return;
            end
            case (mode)
                0, 3: txr = 1'b1;
                2: begin
                    txr = !(i == 3 && stall < 5);
                    if (i == 3) stall++;
                end
                default: txr = 1'($urandom);
            endcase
            check("send_valid", {7'd0, txv}, 8'h01);
            check("send_byte", txd, exp_b[i]);
            check("send_dim", {6'd0, dim}, 8'h02);
            check("send_seq", seq, sq);
            @(posedge clk);
            if (txr) i++;
            @(negedge clk);
            cyc++;
            if (cyc > 200) begin
                check("send_timeout", 8'(i), 8'(NB));
                return;
            end
        end
        check("end_valid", {7'd0, txv}, 8'h00);
        check("end_dim", {6'd0, dim}, 8'h00);
        check("end_seq", seq, sq + 8'd1);
    endtask

    initial begin
        logic [7:0] s;
        axis_val[0] = 16'h1234;
        axis_val[1] = 16'hABCD;
        axis_val[2] = 16'h8001;
        rst = 1'b1;
        txr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check_reset_outputs("reset");
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;

        run_frame(8'h00, 0);
        run_frame(8'h01, 2);
        run_frame(8'h02, 3);
        axis_val[1] = 16'($urandom);
        axis_val[2] = 16'($urandom);
        run_frame(8'h03, 1);
        run_frame(8'h04, 4);
        run_frame(8'h00, 0);

        s = 8'h01;
        for (int f = 0; f < 257; f++) begin
            for (int a = 0; a < 3; a++) axis_val[a] = 16'($urandom);
            run_frame(s, 1);
            s = s + 8'd1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accel_frame_packer.md
# accel_frame_packer

Downstream consumer of the accelerometer SPI configuration/readout stage. It steps that stage's axis selector through X, Y and Z, and waits a programmable dwell on each axis so a fresh high/low byte pair can be read back. It then captures the 16-bit sample and streams the three samples as one byte frame over a valid/ready interface toward the Raspberry Pi link transmitter. It runs entirely in the SPI controller clock domain, so no synchronisers are needed on the sample inputs.

## Interface

Parameters:
- DWELL_CYCLES, default 4096: cycles spent on each axis before capture; legal range 1..2^DWELL_W-1.
- DWELL_W, default 13: width of the dwell counter.

Ports:
- iSPI_CLK, input, 1: sole clock; all state changes on rising edge.
- iRST, input, 1: reset; synchronous and active-high.
- iDATA_L, input, 8: low sample byte from the readout stage.
- iDATA_H, input, 8: high sample byte from the readout stage.
- oDIMENSION, output, 2: axis select to the readout stage; 0=X, 1=Y, 2=Z; value 3 is never driven.
- oTX_DATA, output, 8: frame byte.
- oTX_VALID, output, 1: oTX_DATA is valid.
- iTX_READY, input, 1: sink accepts the byte this cycle.
- oSEQ, output, 8: sequence number of the frame currently being or next to be sent.

## Operation

States:
- DWELL: dwell counter cnt runs; sampling of the selected axis.
- SEND: frame bytes are being emitted.

DWELL:
- cnt increments every cycle.
- On the edge where cnt == DWELL_CYCLES-1:
  - latch {iDATA_H,iDATA_L} into sample[oDIMENSION];
  - cnt <= 0;
  - if oDIMENSION < 2: oDIMENSION <= oDIMENSION+1;
  - else: state <= SEND, oTX_VALID <= 1, oTX_DATA <= 8'hA5, idx <= 0.

SEND:
- oDIMENSION holds at 2.
- A transfer occurs on an edge where oTX_VALID && iTX_READY.
- On a transfer:
  - if idx == LAST: oTX_VALID <= 0, oSEQ <= oSEQ+1 (8-bit wrap, 0xFF -> 0x00), oDIMENSION <= 0, cnt <= 0, state <= DWELL;
  - else: idx <= idx+1, oTX_DATA <= byte[idx+1].
- With no transfer, oTX_DATA and oTX_VALID hold; bytes are never skipped or duplicated.
- iTX_READY is ignored while oTX_VALID is 0.

Frame byte order (idx 0..8):
- A5, SEQ, XL, XH, YL, YH, ZL, ZH, CHK.
- CHK is the XOR of bytes 1..7.
- LAST = 8.
- Samples are frozen at capture time; SEQ is the value of oSEQ during the frame.

## Timing

- Reset values: oDIMENSION=0, oTX_DATA=8'h00, oTX_VALID=0, oSEQ=8'h00, cnt=0, idx=0, state=DWELL, all samples 0.
- After reset release, X, Y and Z are captured on edges DWELL_CYCLES, 2·DWELL_CYCLES and 3·DWELL_CYCLES.
- oTX_VALID rises on edge 3·DWELL_CYCLES.
- oDIMENSION changes on the same edge as the capture of the previous axis.
- With iTX_READY held high, one byte transfers per cycle: SEND lasts 9 cycles.
- Minimum frame period is 3·DWELL_CYCLES + 9 cycles (+8 without the checksum).
- iRST asserted in any state, including mid-frame, forces the reset values on the next edge. The partial frame is abandoned, and the next frame begins at SEQ 00.

## Configuration

- FRAME_CHECKSUM_EN defined: frames are 9 bytes with CHK at idx 8; LAST = 8.
- FRAME_CHECKSUM_EN undefined: frames are 8 bytes ending at ZH; LAST = 7; no checksum logic. All other timing is unchanged.

## Test plan

- Reset: hold iRST for 3 cycles with iTX_READY=1 -> oTX_VALID=0, oDIMENSION=0, oSEQ=00, oTX_DATA=00 throughout.
- Nominal frame: DWELL_CYCLES=4; the model returns X=0x1234, Y=0xABCD, Z=0x8001 by oDIMENSION; iTX_READY=1 -> oDIMENSION steps 0,1,2 at edges 4 and 8; valid rises at edge 12; bytes are A5 00 34 12 CD AB 01 80 C1; then oDIMENSION=0 and oSEQ=01.
- Backpressure: drop iTX_READY for 5 cycles while byte idx 3 (0x12) is presented -> 0x12 is held stable with valid high; the stream resumes with CD and no loss or duplication.
- Sample freeze: change the model's X value during SEND -> the current frame still carries 34 12; the next frame carries the new value.
- Sequence wrap: run 257 frames -> SEQ bytes go …FE, FF, 00; CHK is correct on each frame.
- Mid-frame reset: assert iRST for 1 cycle at idx 4, then FRAME_CHECKSUM_EN undefined build -> valid drops next edge; the next frame is 8 bytes A5 00 … 80 with no CHK; valid falls after ZH.
